imm_ext_pipe: RTL and testbench
===============================

# imm_ext_pipe

Parametrised, registered immediate-extension unit for the datapath decode stage. Extends an IN_W-bit immediate to OUT_W bits under one of several modes, including branch-offset scaling and two-instruction constant fusion (upper half, then lower half). It sits between instruction decode and the ALU/branch operand muxes, with a valid/ready handshake on both sides.

## Interface
- IN_W, 16, immediate input width; ≥ 2
- OUT_W, 32, extended output width; OUT_W ≥ IN_W+2 (elaboration error otherwise)
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  request present
- in_ready  output  1  unit accepts request this cycle
- in_imm  input  IN_W  raw immediate
- in_op  input  3  extension mode
- in_flush  input  1  synchronous pipeline flush
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_imm  output  OUT_W  extended result
- out_fused  output  1  result is a fused constant
- out_err  output  1  result came from an illegal op

## Operation
- Modes, from in_op:
  - 000 ZERO: zero-extend.
  - 001 SIGN: sign-extend from in_imm[IN_W-1].
  - 010 HIGH: in_imm placed in out_imm[OUT_W-1 -: IN_W]; lower bits 0.
  - 011 BROFF: sign-extend, then shift left 2; the top 2 extended bits are dropped.
  - 100 FUSE_HI: latch in_imm as held upper; produces no output.
  - 101 FUSE_LO: fuse with the held upper (see below).
  - 110/111: illegal; out_imm is all ones and out_err=1.
- FSM states:
  - IDLE (reset state).
  - HI_HELD: holds the IN_W-bit upper register.
- Transitions, evaluated on an accepted input (in_valid & in_ready):
  - IDLE + FUSE_HI: latch upper, go to HI_HELD, no output.
  - IDLE + FUSE_LO: treated as ZERO, out_fused=0.
  - HI_HELD + FUSE_LO: out_imm = HIGH(upper) | ZERO(in_imm), out_fused=1, go to IDLE.
  - HI_HELD + FUSE_HI: replace upper, stay in HI_HELD, no output.
  - HI_HELD + any other op: discard upper, process op normally, go to IDLE.
- in_flush: forces IDLE and out_valid=0 on the next edge.
  - Takes priority over acceptance and output handshake; any input accepted in the flush cycle is dropped.
  - in_ready does not depend on in_flush.
- Reset values: out_valid=0, out_imm=0, out_fused=0, out_err=0, state IDLE, upper=0.

## Timing
- Single output register; latency is 1 cycle from accept to out_valid.
- in_ready = !out_valid | out_ready (combinational; no bubble at full throughput).
- While out_valid & !out_ready: out_imm, out_fused and out_err hold stable and no input is accepted.
- An accepted FUSE_HI leaves out_valid cleared on the next edge if the current result drains that cycle.
- Back-to-back FUSE_HI then FUSE_LO produces one result 1 cycle after the FUSE_LO accept.
- rst_n asserted mid-fusion clears the held upper immediately; a later FUSE_LO behaves as ZERO.

## Structure
- Shared package:
  - op encodings as localparams (OP_ZERO … OP_FUSE_LO).
  - state encoding.
- One combinational sub-module, imm_ext_core: (in_imm, in_op, upper, fuse_sel) → (imm, fused, err), computing all mode arithmetic.
- Top level holds the FSM, upper register, output register and handshake logic.

## Test plan
All scenarios use IN_W=16, OUT_W=32.
- SIGN 0x8001, then ZERO 0x8001, then HIGH 0x8001 → out_imm 0xFFFF8001, 0x00008001, 0x80010000, one per cycle, with out_ready=1.
- BROFF 0xFFFF → 0xFFFFFFFC; BROFF 0x4000 → 0x00010000.
- FUSE_HI 0x1234, then FUSE_LO 0x5678 → single result 0x12345678 with out_fused=1; no output for the FUSE_HI.
- FUSE_HI 0xABCD, then SIGN 0x0001, then FUSE_LO 0x0002 → 0x00000001 (fused=0), then 0x00000002 (fused=0).
- out_ready=0 for 3 cycles with out_valid=1 → in_ready=0 and out_imm stable; the queued request is accepted the cycle out_ready rises.
- in_op=110 → out_imm 0xFFFFFFFF, out_err=1.
- FUSE_HI 0x1111, then rst_n pulse, then FUSE_LO 0x2222 → 0x00002222, fused=0.
- in_flush during HI_HELD → out_valid=0 on the next cycle, and the same FUSE_LO behaviour as after reset.

Source files
------------

// File: rtl/imm_ext_pipe_pkg.sv
// Shared definitions for the immediate-extension pipeline: op encodings and FSM state.
`timescale 1ns/1ps
package imm_ext_pipe_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_ZERO    = 3'b000;
  localparam op_t OP_SIGN    = 3'b001;
  localparam op_t OP_HIGH    = 3'b010;
  localparam op_t OP_BROFF   = 3'b011;
  localparam op_t OP_FUSE_HI = 3'b100;
  localparam op_t OP_FUSE_LO = 3'b101;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_HI_HELD = 1'b1
  } state_e;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Decode-side request and ALU-side result handshake bundle for imm_ext_pipe.
`timescale 1ns/1ps
interface imm_ext_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [2:0]       in_op;
  logic             in_flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_imm;
  logic             out_fused;
  logic             out_err;

  modport master (
    output in_valid, in_imm, in_op, in_flush, out_ready,
    input  in_ready, out_valid, out_imm, out_fused, out_err
  );

  modport slave (
    input  in_valid, in_imm, in_op, in_flush, out_ready,
    output in_ready, out_valid, out_imm, out_fused, out_err
  );
endinterface

// File: rtl/imm_ext_pipe_core.sv
// Combinational mode arithmetic: turns a raw immediate (plus held upper half) into the extended result.
`timescale 1ns/1ps
module imm_ext_core
  import imm_ext_pipe_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  in_imm,
  input  op_t              in_op,
  input  logic [IN_W-1:0]  upper,
  input  logic             fuse_sel,
  output logic [OUT_W-1:0] imm,
  output logic             fused,
  output logic             err
);

  logic [OUT_W-1:0] zero_ext;
  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] high_imm;
  logic [OUT_W-1:0] high_upper;

  assign zero_ext   = {{(OUT_W-IN_W){1'b0}}, in_imm};
  assign sign_ext   = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
  assign high_imm   = {in_imm, {(OUT_W-IN_W){1'b0}}};
  assign high_upper = {upper,  {(OUT_W-IN_W){1'b0}}};

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    imm   = zero_ext;
    fused = 1'b0;
    err   = 1'b0;
    case (in_op)
      OP_ZERO:    imm = zero_ext;
      OP_SIGN:    imm = sign_ext;
      OP_HIGH:    imm = high_imm;
      OP_BROFF:   imm = sign_ext << 2;
      OP_FUSE_HI: imm = zero_ext;
      OP_FUSE_LO: begin
        // Without a held upper half the low half stands alone as a zero-extend.
        if (fuse_sel) begin
          imm   = high_upper | zero_ext;
          fused = 1'b1;
        end
      end
      default: begin
        imm = '1;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender: fusion FSM, held upper half, one-deep output register, valid/ready.
`timescale 1ns/1ps
module imm_ext_pipe
  import imm_ext_pipe_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  imm_ext_pipe_if.slave bus
);

  if (IN_W < 2) begin : g_in_w_check
    $error("imm_ext_pipe: IN_W must be at least 2");
  end
  if (OUT_W < IN_W + 2) begin : g_out_w_check
    $error("imm_ext_pipe: OUT_W must be at least IN_W+2");
  end

  state_e           state_q, state_d;
  logic [IN_W-1:0]  upper_q, upper_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_imm_q, out_imm_d;
  logic             out_fused_q, out_fused_d;
  logic             out_err_q, out_err_d;

  logic [OUT_W-1:0] core_imm;
  logic             core_fused;
  logic             core_err;
  logic             accept;

  imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .in_imm   (bus.in_imm),
    .in_op    (bus.in_op),
    .upper    (upper_q),
    .fuse_sel (state_q == S_HI_HELD),
    .imm      (core_imm),
    .fused    (core_fused),
    .err      (core_err)
  );

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_imm   = out_imm_q;
  assign bus.out_fused = out_fused_q;
  assign bus.out_err   = out_err_q;

  always_comb begin
    state_d     = state_q;
    upper_d     = upper_q;
    out_valid_d = out_valid_q;
    out_imm_d   = out_imm_q;
    out_fused_d = out_fused_q;
    out_err_d   = out_err_q;
    // Flush wins over both handshakes; a request accepted this cycle is dropped.
    if (bus.in_flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end else if (accept) begin
      if (bus.in_op == OP_FUSE_HI) begin
        upper_d     = bus.in_imm;
        state_d     = S_HI_HELD;
        out_valid_d = 1'b0;
      end else begin
        state_d     = S_IDLE;
        out_valid_d = 1'b1;
        out_imm_d   = core_imm;
        out_fused_d = core_fused;
        out_err_d   = core_err;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: all registers, including the held upper half, reset so a post-reset FUSE_LO is clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      upper_q     <= '0;
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
      out_fused_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      upper_q     <= upper_d;
      out_valid_q <= out_valid_d;
      out_imm_q   <= out_imm_d;
      out_fused_q <= out_fused_d;
      out_err_q   <= out_err_d;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe (IN_W=16, OUT_W=32) with hand-computed expectations.
`timescale 1ns/1ps
module tb_imm_ext_pipe;
  import imm_ext_pipe_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  imm_ext_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();

  imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic valid, input op_t op, input logic [15:0] imm);
    bus.in_valid = valid;
    bus.in_op    = op;
    bus.in_imm   = imm;
  endtask

  // Advance one rising edge, then settle 1ns so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] imm, input logic fused, input logic err);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".imm"},   bus.out_imm,        imm);
    check({tag, ".fused"}, 32'(bus.out_fused), 32'(fused));
    check({tag, ".err"},   32'(bus.out_err),   32'(err));
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_flush  = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, OP_ZERO, 16'h0000);
    tick();
    tick();

    check("rst.valid",    32'(bus.out_valid), 32'd0);
    check("rst.imm",      bus.out_imm,        32'h0);
    check("rst.fused",    32'(bus.out_fused), 32'd0);
    check("rst.err",      32'(bus.out_err),   32'd0);
    check("rst.in_ready", 32'(bus.in_ready),  32'd1);
    rst_n = 1'b1;
    tick();

    // Basic modes at full throughput.
    drive(1'b1, OP_SIGN, 16'h8001);  tick(); expect_out("sign",   32'hFFFF8001, 1'b0, 1'b0);
    drive(1'b1, OP_ZERO, 16'h8001);  tick(); expect_out("zero",   32'h00008001, 1'b0, 1'b0);
    drive(1'b1, OP_HIGH, 16'h8001);  tick(); expect_out("high",   32'h80010000, 1'b0, 1'b0);
    drive(1'b1, OP_BROFF, 16'hFFFF); tick(); expect_out("broff1", 32'hFFFFFFFC, 1'b0, 1'b0);
    drive(1'b1, OP_BROFF, 16'h4000); tick(); expect_out("broff2", 32'h00010000, 1'b0, 1'b0);

    // Fusion: FUSE_HI yields nothing while the previous result drains.
    drive(1'b1, OP_FUSE_HI, 16'h1234); tick();
    check("fuse_hi.valid", 32'(bus.out_valid), 32'd0);
    drive(1'b1, OP_FUSE_LO, 16'h5678); tick(); expect_out("fuse", 32'h12345678, 1'b1, 1'b0);
    drive(1'b0, OP_ZERO, 16'h0000); tick();
    check("fuse.single", 32'(bus.out_valid), 32'd0);

    // An intervening op discards the held upper half.
    drive(1'b1, OP_FUSE_HI, 16'hABCD); tick();
    check("discard.hi_valid", 32'(bus.out_valid), 32'd0);
    drive(1'b1, OP_SIGN, 16'h0001);    tick(); expect_out("discard.sign", 32'h00000001, 1'b0, 1'b0);
    drive(1'b1, OP_FUSE_LO, 16'h0002); tick(); expect_out("discard.lo",   32'h00000002, 1'b0, 1'b0);

    // FUSE_HI in HI_HELD replaces the upper half.
    drive(1'b1, OP_FUSE_HI, 16'h1111); tick();
    drive(1'b1, OP_FUSE_HI, 16'h9999); tick();
    check("replace.hi_valid", 32'(bus.out_valid), 32'd0);
    drive(1'b1, OP_FUSE_LO, 16'h0001); tick(); expect_out("replace", 32'h99990001, 1'b1, 1'b0);
    drive(1'b0, OP_ZERO, 16'h0000); tick();

    // Backpressure: result held stable, queued request waits for out_ready.
    bus.out_ready = 1'b0;
    drive(1'b1, OP_ZERO, 16'h00AA); tick(); expect_out("bp.first", 32'h000000AA, 1'b0, 1'b0);
    drive(1'b1, OP_SIGN, 16'hFFF0);
    for (int i = 0; i < 3; i++) begin
      check("bp.in_ready", 32'(bus.in_ready), 32'd0);
      check("bp.hold",     bus.out_imm,       32'h000000AA);
      check("bp.valid",    32'(bus.out_valid), 32'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(bus.in_ready), 32'd1);
    tick(); expect_out("bp.second", 32'hFFFFFFF0, 1'b0, 1'b0);
    drive(1'b0, OP_ZERO, 16'h0000); tick();
    check("bp.drained", 32'(bus.out_valid), 32'd0);

    // Illegal ops.
    drive(1'b1, 3'b110, 16'h1234); tick(); expect_out("ill110", 32'hFFFFFFFF, 1'b0, 1'b1);
    drive(1'b1, 3'b111, 16'h0000); tick(); expect_out("ill111", 32'hFFFFFFFF, 1'b0, 1'b1);
    drive(1'b1, OP_ZERO, 16'h0003); tick(); expect_out("post_ill", 32'h00000003, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a fusion.
    drive(1'b1, OP_FUSE_HI, 16'h1111); tick();
    drive(1'b0, OP_ZERO, 16'h0000);
    rst_n = 1'b0;
    #2;
    check("arst.valid", 32'(bus.out_valid), 32'd0);
    check("arst.imm",   bus.out_imm,        32'h0);
    rst_n = 1'b1;
    tick();
    drive(1'b1, OP_FUSE_LO, 16'h2222); tick(); expect_out("arst.lo", 32'h00002222, 1'b0, 1'b0);

    // Flush in HI_HELD drops the accepted FUSE_LO and returns to IDLE.
    drive(1'b1, OP_FUSE_HI, 16'h3333); tick();
    drive(1'b1, OP_FUSE_LO, 16'h4444);
    bus.in_flush = 1'b1;
    tick();
    check("flush.valid", 32'(bus.out_valid), 32'd0);
    bus.in_flush = 1'b0;
    drive(1'b1, OP_FUSE_LO, 16'h5555); tick(); expect_out("flush.lo", 32'h00005555, 1'b0, 1'b0);

    // Flush clears a stalled result; in_ready ignores the flush.
    bus.out_ready = 1'b0;
    drive(1'b0, OP_ZERO, 16'h0000);
    tick();
    check("flush_bp.valid_before", 32'(bus.out_valid), 32'd1);
    bus.in_flush = 1'b1;
    #1;
    check("flush_bp.in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.in_flush = 1'b0;
    check("flush_bp.valid_after", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
